// File: rtl/context_sequencer.sv
// context_sequencer: context memory plus a sequencer that issues num_ctx
// context words per iteration, iter_count times, into a PE configuration
// input. The memory is loaded while idle. The issued word is registered.
// A no-op context (all zeros) is driven whenever the sequencer is not running.
module context_sequencer #(
  parameter int ContextWidth = 22,
  parameter int Depth        = 16,
  parameter int AddrWidth    = $clog2(Depth)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_wr_en,
  input  logic [AddrWidth-1:0]    cfg_wr_addr,
  input  logic [ContextWidth-1:0] cfg_wr_data,
  input  logic                    start,
  input  logic [AddrWidth:0]      num_ctx,
  input  logic [15:0]             iter_count,
  input  logic                    stall,
  output logic [ContextWidth-1:0] configuration,
  output logic [AddrWidth-1:0]    ctx_index,
  output logic                    busy,
  output logic                    done,
  output logic                    wr_err,
  output logic [1:0]              dbg_state
);

  // Control semantics: start is a level sampled every cycle and is accepted
  // only in IDLE. There is no ready signal; a start seen in RUN or FINISH is
  // simply dropped. Configuration writes are accepted only in IDLE. A write
  // attempted in any other state is dropped and reported by a one-cycle
  // wr_err pulse on the following cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [AddrWidth:0] DepthV = (AddrWidth+1)'(Depth);

  state_e                  state_q, state_d;
  logic [ContextWidth-1:0] mem_q [Depth];
  logic [ContextWidth-1:0] cfg_q, cfg_d;
  logic [AddrWidth-1:0]    idx_q, idx_d;
  logic [AddrWidth-1:0]    pc_q, pc_d;
  logic [15:0]             iter_q, iter_d;
  logic [AddrWidth:0]      num_q, num_d;
  logic [15:0]             iters_q, iters_d;
  logic                    wr_err_q, wr_err_d;

  logic start_ok;
  logic last_pc;
  logic last_iter;

  // A run is only meaningful with 1..Depth contexts and a non-zero iteration count.
  assign start_ok  = (num_ctx != '0) && (num_ctx <= DepthV) && (iter_count != 16'd0);
  assign last_pc   = ({1'b0, pc_q} == (num_q - (AddrWidth+1)'(1)));
  assign last_iter = (iter_q == (iters_q - 16'd1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. A rejected start still passes through FINISH so the
  // caller always gets a done pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = start_ok ? RUN : FINISH;
      end
      RUN: begin
        if (!stall && last_pc && last_iter) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == FINISH);
    dbg_state = state_q;
  end

  // Datapath next-state. Memory is read on RUN edges only. A write in the
  // same cycle as an accepted start is therefore always seen by the run.
  always_comb begin
    cfg_d    = cfg_q;
    idx_d    = idx_q;
    pc_d     = pc_q;
    iter_d   = iter_q;
    num_d    = num_q;
    iters_d  = iters_q;
    wr_err_d = cfg_wr_en && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        cfg_d = '0;
        if (start && start_ok) begin
          num_d   = num_ctx;
          iters_d = iter_count;
          pc_d    = '0;
          iter_d  = 16'd0;
        end
      end
      RUN: begin
        if (!stall) begin
          cfg_d = mem_q[pc_q];
          idx_d = pc_q;
          if (last_pc) begin
            pc_d   = '0;
            iter_d = iter_q + 16'd1;
          end else begin
            pc_d = pc_q + AddrWidth'(1);
          end
        end
      end
      FINISH:  cfg_d = '0;
      default: cfg_d = '0;
    endcase
  end

  // Datapath registers. Reset clears everything except the context memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q    <= '0;
      idx_q    <= '0;
      pc_q     <= '0;
      iter_q   <= 16'd0;
      num_q    <= '0;
      iters_q  <= 16'd0;
      wr_err_q <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      idx_q    <= idx_d;
      pc_q     <= pc_d;
      iter_q   <= iter_d;
      num_q    <= num_d;
      iters_q  <= iters_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Context memory: written only while idle. It is deliberately not reset.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && (state_q == IDLE)) mem_q[cfg_wr_addr] <= cfg_wr_data;
  end

  assign configuration = cfg_q;
  assign ctx_index     = idx_q;
  assign wr_err        = wr_err_q;

endmodule

// File: tb/tb_context_sequencer.sv
// Directed bench for context_sequencer. A reference copy of the context
// memory lives in the bench. Expected configuration and index streams are
// queued per run and compared cycle by cycle.
module tb_context_sequencer;

  localparam int CW = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_wr_en;
  logic [3:0]    cfg_wr_addr;
  logic [CW-1:0] cfg_wr_data;
  logic          start;
  logic [4:0]    num_ctx;
  logic [15:0]   iter_count;
  logic          stall;
  logic [CW-1:0] configuration;
  logic [3:0]    ctx_index;
  logic          busy;
  logic          done;
  logic          wr_err;
  logic [1:0]    dbg_state;

  logic [CW-1:0] exp_q[$];
  logic [3:0]    idx_q[$];
  logic [CW-1:0] mem_m[16];

  int total = 0;
  int bad   = 0;

  context_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .start(start), .num_ctx(num_ctx), .iter_count(iter_count), .stall(stall),
    .configuration(configuration), .ctx_index(ctx_index),
    .busy(busy), .done(done), .wr_err(wr_err), .dbg_state(dbg_state)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  // Advance one edge and settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic write_slot(input int a, input logic [CW-1:0] d);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 4'(a);
    cfg_wr_data = d;
    mem_m[a]    = d;
    step();
    cfg_wr_en = 1'b0;
    check_eq("wr_err_idle", {31'd0, wr_err}, 32'd0);
  endtask

  // Queue the expected stream of a stall-free run, ending in the no-op context.
  task automatic push_prog(input int n, input int it);
    for (int i = 0; i < it; i++)
      for (int p = 0; p < n; p++) begin
        exp_q.push_back(mem_m[p]);
        idx_q.push_back(4'(p));
      end
    exp_q.push_back('0);
  endtask

  // Start a run and compare against the queued streams from the first issue
  // edge onward. Optionally stall after sample stall_at for stall_len edges,
  // and optionally attempt a write after sample wr_at.
  task automatic run_prog(input int n, input int it, input int stall_at, input int stall_len,
                          input int wr_at, input int exp_busy);
    int busy_cnt;
    int done_cnt;
    int stall_rem;
    bit wr_chk;
    start      = 1'b1;
    num_ctx    = 5'(n);
    iter_count = 16'(it);
    step();
    start     = 1'b0;
    cfg_wr_en = 1'b0;
    busy_cnt  = int'(busy);
    done_cnt  = int'(done);
    stall_rem = 0;
    wr_chk    = 1'b0;
    check_eq("cfg_after_start", configuration, '0);
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
      step();
      if (stall_rem > 0) begin
        stall_rem--;
        if (stall_rem == 0) stall = 1'b0;
      end
      if (wr_chk) begin
        check_eq("wr_err_pulse", {31'd0, wr_err}, 32'd1);
        cfg_wr_en = 1'b0;
        wr_chk    = 1'b0;
      end
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      check_eq("cfg_seq", configuration, exp_q.pop_front());
      if (idx_q.size() > 0) check_eq("ctx_index", ctx_index, idx_q.pop_front());
      if (c == stall_at) begin
        stall     = 1'b1;
        stall_rem = stall_len;
      end
      if (c == wr_at) begin
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 4'd1;
        cfg_wr_data = 22'h3FFFFF;
        wr_chk      = 1'b1;
      end
    end
    if (exp_q.size() > 0) check_eq("seq_timeout", exp_q.size(), 0);
    exp_q.delete();
    idx_q.delete();
    stall     = 1'b0;
    cfg_wr_en = 1'b0;
    check_eq("busy_cycles", busy_cnt, exp_busy);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("end_state_idle", {30'd0, dbg_state}, 32'd0);
    check_eq("wr_err_quiet", {31'd0, wr_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    start = 1'b0; num_ctx = '0; iter_count = '0; stall = 1'b0;
    step();
    step();
    check_eq("rst_cfg",    configuration, '0);
    check_eq("rst_idx",    {28'd0, ctx_index}, 32'd0);
    check_eq("rst_busy",   {31'd0, busy}, 32'd0);
    check_eq("rst_done",   {31'd0, done}, 32'd0);
    check_eq("rst_wr_err", {31'd0, wr_err}, 32'd0);
    check_eq("rst_state",  {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    step();

    write_slot(0, 22'h00A);
    write_slot(1, 22'h00B);
    write_slot(2, 22'h00C);

    // Basic program: 3 contexts x 2 iterations.
    push_prog(3, 2);
    run_prog(3, 2, -1, 0, -1, 6);

    // Stall for three edges while 0x00B is on the output.
    exp_q = '{22'h00A, 22'h00B, 22'h00B, 22'h00B, 22'h00B, 22'h00C,
              22'h00A, 22'h00B, 22'h00C, 22'h000};
    idx_q = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
    run_prog(3, 2, 1, 3, -1, 9);

    // Rejected starts: zero iterations, zero contexts, too many contexts.
    exp_q.push_back('0);
    run_prog(3, 0, -1, 0, -1, 0);
    exp_q.push_back('0);
    run_prog(0, 2, -1, 0, -1, 0);
    exp_q.push_back('0);
    run_prog(17, 1, -1, 0, -1, 0);

    // Write during RUN is dropped; a later run still sees the original slot 1.
    push_prog(3, 2);
    run_prog(3, 2, -1, 0, 0, 6);
    push_prog(3, 1);
    run_prog(3, 1, -1, 0, -1, 3);

    // Write in the same cycle as an accepted start is used by that run.
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 4'd2;
    cfg_wr_data = 22'h155;
    mem_m[2]    = 22'h155;
    push_prog(3, 1);
    run_prog(3, 1, -1, 0, -1, 3);
    write_slot(2, 22'h00C);

    // Reset while 0x00B is driven, then replay with memory intact.
    start = 1'b1; num_ctx = 5'd3; iter_count = 16'd2;
    step();
    start = 1'b0;
    step();
    check_eq("pre_rst_a", configuration, 22'h00A);
    step();
    check_eq("pre_rst_b", configuration, 22'h00B);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("post_rst_cfg",   configuration, '0);
    check_eq("post_rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("post_rst_state", {30'd0, dbg_state}, 32'd0);
    check_eq("post_rst_idx",   {28'd0, ctx_index}, 32'd0);
    push_prog(3, 2);
    run_prog(3, 2, -1, 0, -1, 6);

    // Single context reissued each cycle.
    push_prog(1, 3);
    run_prog(1, 3, -1, 0, -1, 3);

    // Full depth, one iteration.
    for (int i = 0; i < 16; i++) write_slot(i, 22'(32'h100 + i * 32'h11));
    push_prog(16, 1);
    run_prog(16, 1, -1, 0, -1, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
